// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx byte channel among NREQ requesters.
// A grant is held for a whole message, up to MAX_BURST bytes, or until the owner idles out.
module uart_tx_arbiter #(
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_last,
  input  logic [NREQ*8-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic [NREQ-1:0]   grant,
  output logic              busy
);

  localparam int PW = $clog2(NREQ);
  localparam logic [PW:0] NR = (PW+1)'(NREQ);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]    state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] gidx;
  logic [PW-1:0] win;
  logic [PW-1:0] nptr;
  logic [PW:0]   s;
  logic          found;
  logic [7:0]    buf_data;
  logic          buf_last;
  logic          buf_full;
  logic [7:0]    burst_cnt;
  logic [7:0]    to_cnt;
  logic          g_valid;
  logic          g_last;
  logic [7:0]    g_data;
  logic          up;
  logic          dn;
  logic          rel_dn;
  logic          rel_to;

  // Scan from ptr upward, wrapping, for the first valid requester.
  always_comb begin
    win   = ptr;
    found = 1'b0;
    s     = '0;
    for (int k = 0; k < NREQ; k++) begin
      s = {1'b0, ptr} + (PW+1)'(k);
      if (s >= NR) s = s - NR;
      if (!found && req_valid[s[PW-1:0]]) begin
        found = 1'b1;
        win   = s[PW-1:0];
      end
    end
  end

  always_comb begin
    g_valid = req_valid[gidx];
    g_last  = req_last[gidx];
    g_data  = req_data[{gidx, 3'b000} +: 8];
    up      = (state == GRANT) && !buf_full && g_valid;
    dn      = buf_full && tx_ready;
    rel_dn  = dn && (buf_last || burst_cnt == 8'(MAX_BURST));
    rel_to  = (state == GRANT) && !buf_full && !g_valid
              && to_cnt == 8'(TIMEOUT - 1);
    nptr    = (gidx == PW'(NREQ - 1)) ? '0 : gidx + PW'(1);
  end

  assign req_ready = (state == GRANT && !buf_full) ? grant : '0;
  assign tx_valid  = buf_full;
  assign tx_data   = buf_data;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      ptr       <= '0;
      gidx      <= '0;
      grant     <= '0;
      buf_data  <= 8'h00;
      buf_last  <= 1'b0;
      buf_full  <= 1'b0;
      burst_cnt <= 8'd0;
      to_cnt    <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state     <= GRANT;
            gidx      <= win;
            grant     <= {{(NREQ-1){1'b0}}, 1'b1} << win;
            burst_cnt <= 8'd0;
            to_cnt    <= 8'd0;
          end
        end
        GRANT: begin
          if (up) begin
            buf_data  <= g_data;
            buf_last  <= g_last;
            buf_full  <= 1'b1;
            burst_cnt <= burst_cnt + 8'd1;
            to_cnt    <= 8'd0;
          end else if (g_valid) begin
            to_cnt <= 8'd0;
          end else if (!buf_full) begin
            to_cnt <= to_cnt + 8'd1;
          end
          if (dn) buf_full <= 1'b0;
          if (rel_dn || rel_to) begin
            state <= IDLE;
            grant <= '0;
            ptr   <= nptr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset, messages, round-robin,
// backpressure, burst cap and idle timeout.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_last = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic [3:0]  grant;
  logic        busy;

  int passed = 0;
  int total  = 0;

  uart_tx_arbiter #(
    .NREQ(4),
    .MAX_BURST(16),
    .TIMEOUT(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_last(req_last),
    .req_data(req_data),
    .req_ready(req_ready),
    .tx_valid(tx_valid),
    .tx_data(tx_data),
    .tx_ready(tx_ready),
    .grant(grant),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic set_data(input int i, input logic [7:0] d);
    req_data[i*8 +: 8] = d;
  endtask

  logic [3:0] rr_grant [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [7:0] rr_tag   [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};

  initial begin
    // T1 reset with all requesters asserting
    rst = 1'b0;
    req_valid = 4'hF;
    repeat (3) tick();
    chk("rst_grant", grant, 4'b0000);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_req_ready", req_ready, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    rst = 1'b1;
    tick();
    chk("t1_first_grant", grant, 4'b0001);
    chk("t1_busy", busy, 1'b1);

    // T2 single two-byte message from req0
    req_valid = 4'b0001;
    req_last = 4'b0000;
    set_data(0, 8'hA5);
    tx_ready = 1'b1;
    chk("t2_ready0", req_ready, 4'b0001);
    tick();
    chk("t2_tx_valid_a5", tx_valid, 1'b1);
    chk("t2_tx_data_a5", tx_data, 8'hA5);
    chk("t2_ready_full", req_ready, 4'b0000);
    set_data(0, 8'h5A);
    req_last = 4'b0001;
    tick();
    chk("t2_drained", tx_valid, 1'b0);
    chk("t2_ready_again", req_ready, 4'b0001);
    chk("t2_still_grant", grant, 4'b0001);
    tick();
    chk("t2_tx_data_5a", tx_data, 8'h5A);
    chk("t2_tx_valid_5a", tx_valid, 1'b1);
    req_valid = 4'b0000;
    req_last = 4'b0000;
    tick();
    chk("t2_release_grant", grant, 4'b0000);
    chk("t2_release_busy", busy, 1'b0);
    chk("t2_release_txv", tx_valid, 1'b0);
    req_valid = 4'b0011;
    tick();
    chk("t2_next_ptr", grant, 4'b0010);

    // Reset in the middle of a grant
    rst = 1'b0;
    tick();
    chk("midrst_grant", grant, 4'b0000);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_txv", tx_valid, 1'b0);

    // T3 round-robin, one last byte each
    rst = 1'b1;
    req_valid = 4'hF;
    req_last = 4'hF;
    req_data = 32'h13121110;
    for (int n = 0; n < 5; n++) begin
      tick();
      chk("t3_grant", grant, rr_grant[n]);
      tick();
      chk("t3_tx_data", tx_data, rr_tag[n]);
      chk("t3_tx_valid", tx_valid, 1'b1);
      tick();
      chk("t3_release", grant, 4'b0000);
    end

    // T4 backpressure with 3C buffered
    req_valid = 4'b0100;
    req_last = 4'b0100;
    set_data(2, 8'h3C);
    tx_ready = 1'b0;
    tick();
    chk("t4_grant", grant, 4'b0100);
    tick();
    for (int i = 0; i < 20; i++) begin
      chk("t4_tx_valid", tx_valid, 1'b1);
      chk("t4_tx_data", tx_data, 8'h3C);
      chk("t4_req_ready", req_ready, 4'b0000);
      tick();
    end
    chk("t4_hold_grant", grant, 4'b0100);
    tx_ready = 1'b1;
    tick();
    chk("t4_release", grant, 4'b0000);

    // T5 burst cap: req2 streams, req1 waits
    req_valid = 4'b0100;
    req_last = 4'b0000;
    tick();
    chk("t5_grant2", grant, 4'b0100);
    req_valid = 4'b0110;
    req_last = 4'b0010;
    set_data(1, 8'hB1);
    for (int n = 0; n < 16; n++) begin
      set_data(2, 8'h20 + 8'(n));
      chk("t5_ready_owner_only", req_ready, 4'b0100);
      tick();
      chk("t5_tx_data", tx_data, 8'h20 + 8'(n));
      chk("t5_grant_held", grant, 4'b0100);
      tick();
    end
    chk("t5_cap_release", grant, 4'b0000);
    tick();
    chk("t5_grant1", grant, 4'b0010);
    tick();
    chk("t5_tx_b1", tx_data, 8'hB1);
    req_valid = 4'b0100;
    req_last = 4'b0100;
    set_data(2, 8'h30);
    tick();
    chk("t5_rel1", grant, 4'b0000);
    tick();
    chk("t5_resume2", grant, 4'b0100);
    tick();
    chk("t5_tx_30", tx_data, 8'h30);
    req_valid = 4'b0000;
    req_last = 4'b0000;
    tick();
    chk("t5_done_busy", busy, 1'b0);

    // T6 idle timeout after one non-last byte
    req_valid = 4'b0010;
    req_last = 4'b0000;
    set_data(1, 8'hC3);
    tick();
    chk("t6_grant1", grant, 4'b0010);
    tick();
    chk("t6_tx_c3", tx_data, 8'hC3);
    req_valid = 4'b0000;
    tick();
    chk("t6_drained", tx_valid, 1'b0);
    repeat (63) tick();
    chk("t6_before_to_grant", grant, 4'b0010);
    chk("t6_before_to_busy", busy, 1'b1);
    tick();
    chk("t6_to_grant", grant, 4'b0000);
    chk("t6_to_busy", busy, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
